// File: rtl/ppu_pkg.sv
`default_nettype none
// ============================================================================
// Package : ppu_pkg
// Shared FSM state encoding, attribute-word field layout and default sizes
// for the sprite line evaluator.
// Rev     : 1.0
// ============================================================================
package ppu_pkg;

  typedef logic [1:0] ppu_state_t;

  localparam ppu_state_t c_ST_IDLE   = 2'd0;
  localparam ppu_state_t c_ST_SCAN   = 2'd1;
  localparam ppu_state_t c_ST_FETCH  = 2'd2;
  localparam ppu_state_t c_ST_COMMIT = 2'd3;

  localparam int c_DEF_N_SPR    = 16;
  localparam int c_DEF_MAX_LINE = 4;
  localparam int c_DEF_SPR_SIZE = 16;
  localparam int c_DEF_BPP      = 2;
  localparam int c_DEF_PAT_W    = 6;
  localparam int c_DEF_PAL_W    = 2;
  localparam int c_DEF_X_W      = 12;
  localparam int c_DEF_Y_W      = 11;

  // Attribute word, LSB first: x, y, pattern, hflip, palette
  function automatic int attr_y_lsb(input int x_w);
    return x_w;
  endfunction

  function automatic int attr_pat_lsb(input int x_w, input int y_w);
    return x_w + y_w;
  endfunction

  function automatic int attr_hflip_bit(input int x_w, input int y_w, input int pat_w);
    return x_w + y_w + pat_w;
  endfunction

  function automatic int attr_pal_lsb(input int x_w, input int y_w, input int pat_w);
    return x_w + y_w + pat_w + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ppu_sprite_slot.sv
`default_nettype none
// ============================================================================
// Module : ppu_sprite_slot
// One active sprite slot: holds x, pattern row, palette (and hflip when
// PPU_HFLIP_EN is defined) and returns the colour under display_col.
// Rev    : 1.0
// ============================================================================
module ppu_sprite_slot #(
  parameter int X_W      = 12,
  parameter int SPR_SIZE = 16,
  parameter int BPP      = 2,
  parameter int PAL_W    = 2
)(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_load,
  input  logic                    i_load_valid,
  input  logic [X_W-1:0]          i_load_x,
  input  logic [SPR_SIZE*BPP-1:0] i_load_row,
  input  logic [PAL_W-1:0]        i_load_pal,
`ifdef PPU_HFLIP_EN
  input  logic                    i_load_hflip,
`endif
  input  logic [X_W-1:0]          i_display_col,
  output logic [BPP-1:0]          o_colour,
  output logic [PAL_W-1:0]        o_palette
);

  localparam int             c_OW   = $clog2(SPR_SIZE);
  localparam logic [X_W-1:0] c_SZ_X = X_W'(SPR_SIZE);

  logic                    r_valid;
  logic [X_W-1:0]          r_x;
  logic [SPR_SIZE*BPP-1:0] r_row;
  logic [PAL_W-1:0]        r_pal;
  logic [X_W-1:0]          w_dx;
  logic                    w_cover;
  logic [c_OW-1:0]         w_pix;
  logic [BPP-1:0]          w_colour;

`ifdef PPU_HFLIP_EN
  logic r_hflip;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_x     <= '0;
      r_row   <= '0;
      r_pal   <= '0;
`ifdef PPU_HFLIP_EN
      r_hflip <= 1'b0;
`endif
    end else if (i_load) begin
      r_valid <= i_load_valid;
      r_x     <= i_load_x;
      r_row   <= i_load_row;
      r_pal   <= i_load_pal;
`ifdef PPU_HFLIP_EN
      r_hflip <= i_load_hflip;
`endif
    end
  end

  // Modular distance gives the wrap-around coverage at the screen edge
  assign w_dx    = i_display_col - r_x;
  assign w_cover = r_valid && (w_dx < c_SZ_X);

`ifdef PPU_HFLIP_EN
  assign w_pix = r_hflip ? ~w_dx[c_OW-1:0] : w_dx[c_OW-1:0];
`else
  assign w_pix = w_dx[c_OW-1:0];
`endif

  always_comb begin
    w_colour = '0;
    for (int p = 0; p < SPR_SIZE; p++) begin
      if (w_pix == c_OW'(p)) w_colour = r_row[BPP*p +: BPP];
    end
  end

  assign o_colour  = w_cover ? w_colour : '0;
  assign o_palette = r_pal;

endmodule
`default_nettype wire

// File: rtl/ppu_sprite_line.sv
`default_nettype none
// ============================================================================
// Module : ppu_sprite_line
// Per-line sprite evaluator: scans the attribute table, fetches pattern rows
// for up to MAX_LINE hits, commits them and mixes pixels for the display.
// Optional horizontal flip is enabled by defining PPU_HFLIP_EN.
// Rev    : 1.0
// ============================================================================
module ppu_sprite_line
  import ppu_pkg::*;
#(
  parameter int  N_SPR    = c_DEF_N_SPR,
  parameter int  MAX_LINE = c_DEF_MAX_LINE,
  parameter int  SPR_SIZE = c_DEF_SPR_SIZE,
  parameter int  BPP      = c_DEF_BPP,
  parameter int  PAT_W    = c_DEF_PAT_W,
  parameter int  PAL_W    = c_DEF_PAL_W,
  parameter int  X_W      = c_DEF_X_W,
  parameter int  Y_W      = c_DEF_Y_W,
  localparam int c_AW     = (N_SPR > 1) ? $clog2(N_SPR) : 1,
  localparam int c_OW     = $clog2(SPR_SIZE),
  localparam int c_AD_W   = X_W + Y_W + PAT_W + 1 + PAL_W
)(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    line_start,
  input  logic [Y_W-1:0]          next_row,
  output logic [c_AW-1:0]         attr_addr,
  input  logic [c_AD_W-1:0]       attr_data,
  output logic [PAT_W+c_OW-1:0]   pat_addr,
  input  logic [SPR_SIZE*BPP-1:0] pat_data,
  input  logic                    visible,
  input  logic [X_W-1:0]          display_col,
  output logic                    pix_valid,
  output logic [PAL_W+BPP-1:0]    pix_index,
  output logic                    busy,
  output logic                    overflow
);

  localparam int             c_SW     = $clog2(N_SPR + 1);
  localparam int             c_Y_LSB  = attr_y_lsb(X_W);
  localparam int             c_P_LSB  = attr_pat_lsb(X_W, Y_W);
  localparam int             c_HF_BIT = attr_hflip_bit(X_W, Y_W, PAT_W);
  localparam int             c_PL_LSB = attr_pal_lsb(X_W, Y_W, PAT_W);
  localparam logic [Y_W-1:0] c_SZ_Y   = Y_W'(SPR_SIZE);

  ppu_state_t              r_state;
  logic [Y_W-1:0]          r_row;
  logic [c_AW-1:0]         r_attr_addr;
  logic [c_SW-1:0]         r_scan_cnt;
  logic [3:0]              r_fill;
  logic [3:0]              r_fetch_idx;
  logic                    r_overflow;
  logic                    r_pix_valid;
  logic [PAL_W+BPP-1:0]    r_pix_index;

  logic [X_W-1:0]          r_sh_x   [MAX_LINE];
  logic [PAT_W-1:0]        r_sh_pat [MAX_LINE];
  logic [c_OW-1:0]         r_sh_off [MAX_LINE];
  logic [PAL_W-1:0]        r_sh_pal [MAX_LINE];
  logic [SPR_SIZE*BPP-1:0] r_sh_row [MAX_LINE];
`ifdef PPU_HFLIP_EN
  logic                    r_sh_hf  [MAX_LINE];
`else
  logic                    w_unused_hflip;
  assign w_unused_hflip = attr_data[c_HF_BIT];
`endif

  logic [X_W-1:0]          w_ax;
  logic [Y_W-1:0]          w_ay;
  logic [PAT_W-1:0]        w_apat;
  logic [PAL_W-1:0]        w_apal;
  logic [Y_W-1:0]          w_dy;
  logic                    w_hit;
  logic                    w_room;
  logic                    w_last_scan;
  logic [3:0]              w_fill_next;
  logic                    w_commit;
  logic [PAT_W+c_OW-1:0]   w_pat_addr;
  logic [BPP-1:0]          w_slot_col [MAX_LINE];
  logic [PAL_W-1:0]        w_slot_pal [MAX_LINE];
  logic [BPP-1:0]          w_colour;
  logic [PAL_W-1:0]        w_pal;

  assign w_ax   = attr_data[0 +: X_W];
  assign w_ay   = attr_data[c_Y_LSB +: Y_W];
  assign w_apat = attr_data[c_P_LSB +: PAT_W];
  assign w_apal = attr_data[c_PL_LSB +: PAL_W];

  // attr_data lags attr_addr by one cycle, so the first scan cycle has no entry
  assign w_dy        = r_row - w_ay;
  assign w_hit       = (r_state == c_ST_SCAN) && (r_scan_cnt != '0) && (w_dy < c_SZ_Y);
  assign w_room      = r_fill < 4'(MAX_LINE);
  assign w_last_scan = r_scan_cnt == c_SW'(N_SPR);
  assign w_fill_next = r_fill + {3'd0, w_hit && w_room};
  assign w_commit    = (r_state == c_ST_COMMIT) && !line_start;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= c_ST_IDLE;
      r_row       <= '0;
      r_attr_addr <= '0;
      r_scan_cnt  <= '0;
      r_fill      <= '0;
      r_fetch_idx <= '0;
      r_overflow  <= 1'b0;
      for (int s = 0; s < MAX_LINE; s++) begin
        r_sh_x[s]   <= '0;
        r_sh_pat[s] <= '0;
        r_sh_off[s] <= '0;
        r_sh_pal[s] <= '0;
        r_sh_row[s] <= '0;
`ifdef PPU_HFLIP_EN
        r_sh_hf[s]  <= 1'b0;
`endif
      end
    end else if (line_start) begin
      r_state     <= c_ST_SCAN;
      r_row       <= next_row;
      r_attr_addr <= '0;
      r_scan_cnt  <= '0;
      r_fill      <= '0;
      r_fetch_idx <= '0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        c_ST_SCAN: begin
          if (r_attr_addr != c_AW'(N_SPR - 1)) r_attr_addr <= r_attr_addr + c_AW'(1);
          if (w_hit && w_room) begin
            for (int s = 0; s < MAX_LINE; s++) begin
              if (r_fill == 4'(s)) begin
                r_sh_x[s]   <= w_ax;
                r_sh_pat[s] <= w_apat;
                r_sh_off[s] <= w_dy[c_OW-1:0];
                r_sh_pal[s] <= w_apal;
`ifdef PPU_HFLIP_EN
                r_sh_hf[s]  <= attr_data[c_HF_BIT];
`endif
              end
            end
          end
          r_fill <= w_fill_next;
          if (w_hit && !w_room) r_overflow <= 1'b1;
          if (w_last_scan) begin
            r_fetch_idx <= '0;
            r_state     <= (w_fill_next != 4'd0) ? c_ST_FETCH : c_ST_COMMIT;
          end else begin
            r_scan_cnt <= r_scan_cnt + c_SW'(1);
          end
        end
        c_ST_FETCH: begin
          for (int s = 0; s < MAX_LINE; s++) begin
            if (r_fetch_idx == 4'(s + 1)) r_sh_row[s] <= pat_data;
          end
          if (r_fetch_idx == r_fill) r_state <= c_ST_COMMIT;
          else                       r_fetch_idx <= r_fetch_idx + 4'd1;
        end
        c_ST_COMMIT: r_state <= c_ST_IDLE;
        default:     r_state <= c_ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_pat_addr = '0;
    if (r_state == c_ST_FETCH) begin
      for (int s = 0; s < MAX_LINE; s++) begin
        if ((r_fetch_idx == 4'(s)) && (4'(s) < r_fill)) w_pat_addr = {r_sh_pat[s], r_sh_off[s]};
      end
    end
  end

  generate
    for (genvar s = 0; s < MAX_LINE; s++) begin : g_slot
      ppu_sprite_slot #(
        .X_W      (X_W),
        .SPR_SIZE (SPR_SIZE),
        .BPP      (BPP),
        .PAL_W    (PAL_W)
      ) u_slot (
        .clock         (clock),
        .reset         (reset),
        .i_load        (w_commit),
        .i_load_valid  (4'(s) < r_fill),
        .i_load_x      (r_sh_x[s]),
        .i_load_row    (r_sh_row[s]),
        .i_load_pal    (r_sh_pal[s]),
`ifdef PPU_HFLIP_EN
        .i_load_hflip  (r_sh_hf[s]),
`endif
        .i_display_col (display_col),
        .o_colour      (w_slot_col[s]),
        .o_palette     (w_slot_pal[s])
      );
    end
  endgenerate

  // Scan from the highest slot down so the lowest opaque slot wins
  always_comb begin
    w_colour = '0;
    w_pal    = '0;
    for (int s = MAX_LINE - 1; s >= 0; s--) begin
      if (w_slot_col[s] != '0) begin
        w_colour = w_slot_col[s];
        w_pal    = w_slot_pal[s];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pix_valid <= 1'b0;
      r_pix_index <= '0;
    end else if (visible && !busy && (w_colour != '0)) begin
      r_pix_valid <= 1'b1;
      r_pix_index <= {w_pal, w_colour};
    end else begin
      r_pix_valid <= 1'b0;
      r_pix_index <= '0;
    end
  end

  assign busy      = r_state != c_ST_IDLE;
  assign overflow  = r_overflow;
  assign attr_addr = r_attr_addr;
  assign pat_addr  = w_pat_addr;
  assign pix_valid = r_pix_valid;
  assign pix_index = r_pix_index;

endmodule
`default_nettype wire

// File: tb/tb_ppu_sprite_line.sv
`default_nettype none
// ============================================================================
// Module : tb_ppu_sprite_line
// Directed, table-driven bench for ppu_sprite_line with default parameters.
// Rev    : 1.0
// ============================================================================
module tb_ppu_sprite_line;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        line_start = 1'b0;
  logic [10:0] next_row = '0;
  logic [3:0]  attr_addr;
  logic [31:0] attr_data = '0;
  logic [9:0]  pat_addr;
  logic [31:0] pat_data = '0;
  logic        visible = 1'b0;
  logic [11:0] display_col = '0;
  logic        pix_valid;
  logic [3:0]  pix_index;
  logic        busy;
  logic        overflow;

  logic [31:0] attr_mem [16];
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    int          phase;
    logic        vis;
    logic [11:0] col;
    logic        exp_v;
    logic [3:0]  exp_i;
  } vec_t;
  vec_t vecs[$];

  ppu_sprite_line dut (
    .clock       (clock),
    .reset       (reset),
    .line_start  (line_start),
    .next_row    (next_row),
    .attr_addr   (attr_addr),
    .attr_data   (attr_data),
    .pat_addr    (pat_addr),
    .pat_data    (pat_data),
    .visible     (visible),
    .display_col (display_col),
    .pix_valid   (pix_valid),
    .pix_index   (pix_index),
    .busy        (busy),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] pat_row(input logic [9:0] a);
    case (a[9:4])
      6'd1:    return 32'h5555_5555;
      6'd2:    return 32'hAAAA_AAAA;
      6'd3:    return 32'hFFFF_FFFF;
      6'd5:    return 32'h0000_0003;
      6'd6:    return (a[3:0] == 4'd5) ? 32'h0000_0002 : 32'h0000_0001;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clock) begin
    attr_data <= attr_mem[attr_addr];
    pat_data  <= pat_row(pat_addr);
  end

  function automatic logic [31:0] mk_attr(input int x, input int y, input int pat,
                                          input int hf, input int pal);
    return {2'(pal), 1'(hf), 6'(pat), 11'(y), 12'(x)};
  endfunction

  function automatic void add(input int ph, input logic v, input int col,
                              input logic ev, input int ei);
    vec_t t;
    t.phase = ph;
    t.vis   = v;
    t.col   = 12'(col);
    t.exp_v = ev;
    t.exp_i = 4'(ei);
    vecs.push_back(t);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_tab();
    for (int i = 0; i < 16; i++) attr_mem[i] = mk_attr(0, 1500, 4, 0, 0);
  endtask

  task automatic ovf_tab();
    clear_tab();
    for (int i = 0; i < 6; i++) attr_mem[i] = mk_attr(50 + 100 * i, 10, 1, 0, i % 4);
  endtask

  task automatic pulse_start(input int row);
    @(negedge clock);
    next_row   = 11'(row);
    line_start = 1'b1;
    @(negedge clock);
    line_start = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      @(negedge clock);
      cycles++;
    end
  endtask

  task automatic run_line(input int row, input int exp_cycles, input logic exp_ovf,
                          input string tag);
    int cyc;
    pulse_start(row);
    wait_idle(cyc);
    check({tag, " busy cycles"}, cyc, exp_cycles);
    check({tag, " overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
  endtask

  task automatic run_vectors(input int ph);
    foreach (vecs[i]) begin
      if (vecs[i].phase == ph) begin
        @(negedge clock);
        visible     = vecs[i].vis;
        display_col = vecs[i].col;
        @(posedge clock);
        #1;
        check($sformatf("p%0d col%0d valid", ph, vecs[i].col), {31'd0, pix_valid}, {31'd0, vecs[i].exp_v});
        check($sformatf("p%0d col%0d index", ph, vecs[i].col), {28'd0, pix_index}, {28'd0, vecs[i].exp_i});
      end
    end
  endtask

  initial begin
    int cyc;

    add(1, 1, 99, 0, 0);   add(1, 1, 100, 1, 9);  add(1, 1, 107, 1, 9);
    add(1, 1, 115, 1, 9);  add(1, 1, 116, 0, 0);  add(1, 0, 105, 0, 0);
    add(2, 1, 200, 1, 14); add(2, 1, 215, 1, 14); add(2, 1, 216, 0, 0);
    add(2, 1, 300, 1, 2);  add(2, 1, 301, 0, 0);  add(2, 1, 400, 1, 1);
    add(2, 1, 500, 0, 0);  add(2, 1, 600, 0, 0);
    add(3, 1, 200, 1, 7);  add(3, 1, 210, 1, 7);
    add(4, 1, 200, 0, 0);  add(4, 1, 400, 0, 0);
    add(5, 1, 50, 1, 1);   add(5, 1, 150, 1, 5);  add(5, 1, 250, 1, 9);
    add(5, 1, 365, 1, 13); add(5, 1, 450, 0, 0);  add(5, 1, 560, 0, 0);
    add(6, 1, 50, 0, 0);   add(6, 1, 700, 1, 7);  add(6, 1, 715, 1, 7);
    add(6, 1, 800, 1, 10); add(6, 1, 799, 0, 0);
    add(7, 1, 4095, 1, 5); add(7, 1, 5, 1, 5);    add(7, 1, 10, 0, 0);
    add(7, 1, 4089, 0, 0);
`ifdef PPU_HFLIP_EN
    add(7, 1, 0, 1, 5);    add(7, 1, 15, 1, 3);
`else
    add(7, 1, 0, 1, 3);    add(7, 1, 15, 0, 0);
`endif

    clear_tab();
    repeat (3) @(negedge clock);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset overflow", {31'd0, overflow}, 32'd0);
    check("reset pix_valid", {31'd0, pix_valid}, 32'd0);
    check("reset pix_index", {28'd0, pix_index}, 32'd0);
    check("reset attr_addr", {28'd0, attr_addr}, 32'd0);
    check("reset pat_addr", {22'd0, pat_addr}, 32'd0);
    reset = 1'b1;

    // Single sprite, horizontal boundaries
    attr_mem[0] = mk_attr(100, 50, 1, 0, 2);
    run_line(55, 20, 1'b0, "p1");
    run_vectors(1);

    // Priority, row offset and vertical boundaries
    clear_tab();
    attr_mem[0] = mk_attr(200, 50, 4, 0, 1);
    attr_mem[1] = mk_attr(200, 50, 2, 0, 3);
    attr_mem[2] = mk_attr(300, 50, 6, 0, 0);
    attr_mem[3] = mk_attr(400, 40, 1, 0, 0);
    attr_mem[4] = mk_attr(500, 39, 1, 0, 0);
    attr_mem[5] = mk_attr(600, 56, 1, 0, 0);
    run_line(55, 23, 1'b0, "p2");
    run_vectors(2);
    attr_mem[0] = mk_attr(200, 50, 3, 0, 1);
    run_line(55, 23, 1'b0, "p3");
    run_vectors(3);

    // Zero hits go straight to COMMIT and clear the active slots
    clear_tab();
    run_line(1200, 18, 1'b0, "p4");
    run_vectors(4);

    ovf_tab();
    run_line(10, 23, 1'b1, "p5");
    run_vectors(5);

    // Restart mid-FETCH
    clear_tab();
    attr_mem[2] = mk_attr(700, 100, 3, 0, 1);
    attr_mem[7] = mk_attr(800, 100, 2, 0, 2);
    @(negedge clock);
    visible     = 1'b1;
    display_col = 12'd50;
    pulse_start(100);
    check("abort overflow cleared", {31'd0, overflow}, 32'd0);
    repeat (17) @(negedge clock);
    check("abort busy mid-fetch", {31'd0, busy}, 32'd1);
    check("abort pix gated by busy", {31'd0, pix_valid}, 32'd0);
    pulse_start(100);
    wait_idle(cyc);
    check("abort recommit cycles", cyc, 32'd21);
    visible = 1'b0;
    run_vectors(6);

    // Horizontal flip and wrap at the right edge
    clear_tab();
    attr_mem[0] = mk_attr(0, 100, 5, 1, 0);
    attr_mem[1] = mk_attr(4090, 100, 1, 0, 1);
    run_line(100, 21, 1'b0, "p7");
    run_vectors(7);

    // Reset during SCAN
    ovf_tab();
    pulse_start(10);
    repeat (8) @(negedge clock);
    check("pre-reset busy", {31'd0, busy}, 32'd1);
    check("pre-reset overflow", {31'd0, overflow}, 32'd1);
    visible     = 1'b1;
    display_col = 12'd0;
    reset       = 1'b0;
    #1;
    check("in-reset busy", {31'd0, busy}, 32'd0);
    check("in-reset overflow", {31'd0, overflow}, 32'd0);
    check("in-reset pix_valid", {31'd0, pix_valid}, 32'd0);
    repeat (3) begin
      @(posedge clock);
      #1;
      check("held-reset pix_valid", {31'd0, pix_valid}, 32'd0);
    end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("post-reset pix_valid", {31'd0, pix_valid}, 32'd0);
    check("post-reset busy", {31'd0, busy}, 32'd0);
    visible = 1'b0;

    clear_tab();
    attr_mem[0] = mk_attr(100, 50, 1, 0, 2);
    run_line(55, 20, 1'b0, "p8");
    run_vectors(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ppu_sprite_line.md
PPU_SPRITE_LINE -- requirements
Module: ppu_sprite_line

Interface
REQ-001 Parameter N_SPR, default 16: attribute-table entries scanned per line (≥1).
REQ-002 Parameter MAX_LINE, default 4: sprite slots per line (1..8).
REQ-003 Parameter SPR_SIZE, default 16: sprite width/height in pixels (power of 2).
REQ-004 Parameter BPP, default 2: bits per pixel; PAT_W default 6: pattern index width; PAL_W default 2: palette select width.
REQ-005 Parameter X_W, default 12; Y_W, default 11: coordinate widths.
REQ-006 clock  in  1  single system clock, all logic on rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 line_start  in  1  one-cycle pulse, sample next_row and begin line evaluation.
REQ-009 next_row  in  Y_W  display row to be rendered next.
REQ-010 attr_addr  out  clog2(N_SPR)  attribute-table read address; attr_data  in  X_W+Y_W+PAT_W+1+PAL_W  {palette, hflip, pattern, y, x}, valid 1 cycle after address.
REQ-011 pat_addr  out  PAT_W+clog2(SPR_SIZE)  {pattern, row offset}; pat_data  in  SPR_SIZE*BPP  pixel i at [BPP*i +: BPP], pixel 0 leftmost, valid 1 cycle after address.
REQ-012 visible  in  1; display_col  in  X_W  from the VGA controller.
REQ-013 pix_valid  out  1  opaque sprite pixel present; pix_index  out  PAL_W+BPP  {palette, colour}.
REQ-014 busy  out  1  evaluation in progress; overflow  out  1  more than MAX_LINE hits on the line.

Function
REQ-015 FSM states IDLE, SCAN, FETCH, COMMIT; line_start moves any state to SCAN, clears shadow slots and overflow.
REQ-016 SCAN: attr_addr steps 0..N_SPR-1 one per cycle; compare pipelined one cycle; SCAN lasts N_SPR+1 cycles.
REQ-017 Hit when (next_row - y) mod 2^Y_W < SPR_SIZE; hits fill shadow slots in ascending attribute order.
REQ-018 Hit with all MAX_LINE slots full: entry discarded, overflow set (sticky until next line_start).
REQ-019 FETCH: one pat_addr per filled slot, row offset = next_row - y; lasts filled+1 cycles; zero hits skip directly to COMMIT.
REQ-020 COMMIT: shadow slots copied to active slots in one cycle, then IDLE; busy high in SCAN/FETCH/COMMIT only.
REQ-021 Slot covers pixel when (display_col - x) mod 2^X_W < SPR_SIZE; no horizontal wrap past screen edge beyond this modular rule.
REQ-022 Colour 0 transparent; lowest-numbered slot with non-zero colour wins.
REQ-023 pix_valid/pix_index registered, latency exactly 1 cycle from display_col/visible.
REQ-024 pix_valid forced 0 when visible=0 or prior cycle busy=1; pix_index holds 0 whenever pix_valid=0.
REQ-025 line_start mid-SCAN/FETCH aborts: shadow slots discarded, active slots unchanged until the new COMMIT.
REQ-026 Caller guarantees ≥ N_SPR+MAX_LINE+4 cycles between line_start and first visible pixel of that row.

Reset
REQ-027 reset low: FSM IDLE, all slots empty, attr_addr=0, pat_addr=0, busy=0, overflow=0, pix_valid=0, pix_index=0.
REQ-028 reset release mid-frame: no output until a full line_start..COMMIT sequence completes.

Configuration
REQ-029 Macro PPU_HFLIP_EN defined: slot with hflip=1 reads pixel SPR_SIZE-1-offset.
REQ-030 PPU_HFLIP_EN undefined: hflip bit ignored, not stored in slots; pixel offset used directly.

Structure
REQ-031 Package ppu_pkg holds FSM state enum, attribute field offsets, and default parameter constants.
REQ-032 Sub-module ppu_sprite_slot: one active slot (x, pattern row, palette, hflip), outputs colour for display_col; instantiated MAX_LINE times.

Verification
REQ-033 Sprite0 x=100,y=50 row data all colour 1, next_row=55: col 100..115 -> pix_valid=1, pix_index={pal,1}; col 99,116 -> 0.
REQ-034 Six sprites at y=10, next_row=10, MAX_LINE=4: overflow=1, only entries 0..3 rendered.
REQ-035 Slot0 colour 0 over slot1 colour 2 at same x: slot1 colour 2 shown; slot0 colour 3: colour 3 shown.
REQ-036 line_start repeated during FETCH: previous active slots keep rendering; new line committed after N_SPR+hits+3 cycles.
REQ-037 PPU_HFLIP_EN, hflip=1, pixel0=3 rest 0, x=0: colour 3 at col 15 only; without macro at col 0 only.
REQ-038 reset asserted during SCAN: busy=0, overflow=0, pix_valid=0 next cycle and while low.
